// File: rtl/apb_bridge_arbiter_if.sv
// Bus bundle for apb_bridge_arbiter: N_REQ requester-side APB ports plus the single bridge-side port.
// The slave modport is the arbiter's view; the master modport is the requesters/bridge view.
interface apb_bridge_arbiter_if #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned STRB_WD = 4,
  parameter int unsigned PROT_WD = 3
);
  logic [N_REQ-1:0]         s_psel;
  logic [N_REQ-1:0]         s_penable;
  logic [N_REQ-1:0]         s_pwrite;
  logic [N_REQ*ADDR_WD-1:0] s_paddr;
  logic [N_REQ*DATA_WD-1:0] s_pwdata;
  logic [N_REQ*PROT_WD-1:0] s_pprot;
  logic [N_REQ*STRB_WD-1:0] s_pstrb;
  logic [DATA_WD-1:0]       s_prdata;
  logic [N_REQ-1:0]         s_pready;
  logic [N_REQ-1:0]         s_pslverr;

  logic                     m_psel;
  logic                     m_penable;
  logic                     m_pwrite;
  logic [ADDR_WD-1:0]       m_paddr;
  logic [DATA_WD-1:0]       m_pwdata;
  logic [PROT_WD-1:0]       m_pprot;
  logic [STRB_WD-1:0]       m_pstrb;
  logic [DATA_WD-1:0]       m_prdata;
  logic                     m_pready;

  modport slave (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pprot, s_pstrb,
    output s_prdata, s_pready, s_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb,
    input  m_prdata, m_pready
  );

  modport master (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pprot, s_pstrb,
    input  s_prdata, s_pready, s_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb,
    output m_prdata, m_pready
  );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing one APB master port among N_REQ requesters, one transfer in flight.
// Optional access-phase timeout with error completion: define APB_ARB_TIMEOUT_EN.
module apb_bridge_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned ADDR_WD     = 32,
  parameter int unsigned DATA_WD     = 32,
  parameter int unsigned STRB_WD     = 4,
  parameter int unsigned PROT_WD     = 3,
  parameter int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned ID_WD      = $clog2(N_REQ)
) (
  input  logic                a_pclk,
  input  logic                a_prst_n,
  apb_bridge_arbiter_if.slave bus,
  output logic [ID_WD-1:0]    grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e           state_q, state_d;
  logic [ID_WD-1:0] grant_q, grant_d;
  logic [ID_WD-1:0] ptr_q, ptr_d;
  logic [ID_WD-1:0] winner;
  logic [ID_WD-1:0] cand;
  logic             found;
  logic             timeout;
  logic             done;
  int unsigned      gidx;

  // First requesting index at or after ptr_q, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_WD'((32'(ptr_q) + k) % N_REQ);
      if (!found && bus.s_psel[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout = (state_q == StAccess) && !bus.m_pready && (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !bus.m_pready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign done = (state_q == StAccess) && (bus.m_pready || timeout);
  assign gidx = 32'(grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = winner;
          ptr_d   = ID_WD'((32'(winner) + 1) % N_REQ);
          state_d = StSetup;
        end
      end
      StSetup:  state_d = StAccess;
      StAccess: if (done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

  // A response whose requester already dropped psel is discarded
  always_comb begin
    bus.m_psel     = busy;
    bus.m_penable  = (state_q == StAccess);
    bus.m_pwrite   = 1'b0;
    bus.m_paddr    = '0;
    bus.m_pwdata   = '0;
    bus.m_pprot    = '0;
    bus.m_pstrb    = '0;
    bus.s_prdata   = '0;
    bus.s_pready   = '0;
    bus.s_pslverr  = '0;
    if (busy) begin
      bus.m_pwrite = bus.s_pwrite[grant_q];
      bus.m_paddr  = bus.s_paddr[gidx*ADDR_WD +: ADDR_WD];
      bus.m_pwdata = bus.s_pwdata[gidx*DATA_WD +: DATA_WD];
      bus.m_pprot  = bus.s_pprot[gidx*PROT_WD +: PROT_WD];
      bus.m_pstrb  = bus.s_pstrb[gidx*STRB_WD +: STRB_WD];
    end
    if (done && bus.s_psel[grant_q]) begin
      bus.s_pready[grant_q] = 1'b1;
      if (bus.m_pready) begin
        bus.s_prdata = bus.m_prdata;
      end else begin
        bus.s_pslverr[grant_q] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Bench for apb_bridge_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transfer-level round-robin reference model.
module tb_apb_bridge_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = 3;
  localparam int unsigned TO = 4;
  localparam int unsigned IW = $clog2(N);
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          a_pclk = 1'b0;
  logic          a_prst_n = 1'b0;
  logic [IW-1:0] grant_id;
  logic          busy;

  apb_bridge_arbiter_if #(.N_REQ(N), .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW)) bus ();

  apb_bridge_arbiter #(
    .N_REQ(N), .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW), .TIMEOUT_CYC(TO)
  ) dut (
    .a_pclk   (a_pclk),
    .a_prst_n (a_prst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 a_pclk = ~a_pclk;

  // Requester-side stimulus
  logic [N-1:0]  r_sel;
  logic          r_write [N];
  logic [AW-1:0] r_addr  [N];
  logic [DW-1:0] r_wdata [N];
  logic [SW-1:0] r_strb  [N];
  logic [PW-1:0] r_prot  [N];

  always_comb begin
    bus.s_psel    = r_sel;
    bus.s_penable = r_sel;
    bus.s_pwrite  = '0;
    bus.s_paddr   = '0;
    bus.s_pwdata  = '0;
    bus.s_pstrb   = '0;
    bus.s_pprot   = '0;
    for (int i = 0; i < N; i++) begin
      bus.s_pwrite[i]          = r_write[i];
      bus.s_paddr[i*AW +: AW]  = r_addr[i];
      bus.s_pwdata[i*DW +: DW] = r_wdata[i];
      bus.s_pstrb[i*SW +: SW]  = r_strb[i];
      bus.s_pprot[i*PW +: PW]  = r_prot[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: transfer in flight, its age (0 = setup), winner, and rr pointer
  bit           m_active;
  int           m_age;
  int           m_grant;
  int           m_ptr;
  int           m_win;
  bit           m_fin;
  logic [N-1:0] comp_mask;
  logic [DW-1:0] cap_rdata;
  logic         cap_err;
  int           order[$];
  int           lat;
  int           total_comp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] sel, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (sel[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_age = 0; m_grant = 0; m_ptr = 0; m_win = -1; m_fin = 1'b0;
    comp_mask = '0;
  endtask

  task automatic check_cycle();
    int g;
    logic [N-1:0]  er, ee;
    logic [DW-1:0] ed;
    g = m_grant; er = '0; ee = '0; ed = '0; m_fin = 1'b0; m_win = -1;
    check_eq("grant_id", grant_id, g);
    if (!m_active) begin
      check_eq("busy_idle", busy, 0);
      check_eq("m_psel_idle", bus.m_psel, 0);
      check_eq("m_penable_idle", bus.m_penable, 0);
      check_eq("m_paddr_idle", bus.m_paddr, 0);
      check_eq("m_pwdata_idle", bus.m_pwdata, 0);
      check_eq("m_pwrite_idle", bus.m_pwrite, 0);
      if (a_prst_n) m_win = rr_pick(r_sel, m_ptr);
    end else begin
      check_eq("busy", busy, 1);
      check_eq("m_psel", bus.m_psel, 1);
      check_eq("m_penable", bus.m_penable, m_age > 0);
      check_eq("m_pwrite", bus.m_pwrite, r_write[g]);
      check_eq("m_paddr", bus.m_paddr, r_addr[g]);
      check_eq("m_pwdata", bus.m_pwdata, r_wdata[g]);
      check_eq("m_pstrb", bus.m_pstrb, r_strb[g]);
      check_eq("m_pprot", bus.m_pprot, r_prot[g]);
      if (m_age > 0) begin
        m_fin = bus.m_pready || (TO_EN && (m_age - 1) == int'(TO) - 1);
        if (m_fin && r_sel[g]) begin
          er[g] = 1'b1;
          if (bus.m_pready) ed = bus.m_prdata;
          else ee[g] = 1'b1;
        end
      end
    end
    check_eq("s_pready", bus.s_pready, er);
    check_eq("s_pslverr", bus.s_pslverr, ee);
    check_eq("s_prdata", bus.s_prdata, ed);
    if (er != 0) begin
      cap_rdata = bus.s_prdata;
      cap_err   = |bus.s_pslverr;
      total_comp++;
    end
    comp_mask = er;
  endtask

  task automatic tick();
    if (!a_prst_n) begin
      model_reset();
    end else if (!m_active) begin
      if (m_win >= 0) begin
        m_active = 1'b1; m_age = 0; m_grant = m_win; m_ptr = (m_win + 1) % N;
      end
    end else if (m_fin) begin
      m_active = 1'b0;
    end else begin
      m_age++;
    end
  endtask

  task automatic step();
    @(negedge a_pclk);
    check_cycle();
    @(posedge a_pclk);
    tick();
    #1;
  endtask

  task automatic new_req(input int i);
    r_sel[i]   = 1'b1;
    r_write[i] = 1'($urandom_range(0, 1));
    r_addr[i]  = $urandom;
    r_wdata[i] = $urandom;
    r_strb[i]  = SW'($urandom);
    r_prot[i]  = PW'($urandom);
  endtask

  task automatic do_reset();
    a_prst_n = 1'b0;
    r_sel = '0;
    bus.m_pready = 1'b0;
    model_reset();
    step();
    a_prst_n = 1'b1;
  endtask

  // Requesters in mask hold psel until count transfers complete; bridge stalls wait_n access cycles
  task automatic serve(input logic [N-1:0] mask, input int count, input int wait_n,
                       input logic [AW-1:0] addr, input logic wr);
    int done_n;
    int cyc;
    done_n = 0; cyc = 0; lat = -1; order.delete();
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        new_req(i); r_addr[i] = addr; r_write[i] = wr;
      end
    end
    while (done_n < count && cyc < 200) begin
      bus.m_pready = m_active && (m_age >= 1) && ((m_age - 1) >= wait_n);
      step();
      for (int i = 0; i < N; i++) begin
        if (comp_mask[i]) begin
          order.push_back(i);
          done_n++;
          if (lat < 0) lat = cyc;
          new_req(i); r_addr[i] = addr; r_write[i] = wr;
        end
      end
      cyc++;
    end
    check_eq("serve_done", done_n, count);
    r_sel = '0;
    bus.m_pready = 1'b0;
  endtask

  initial begin
    r_sel = '0;
    for (int i = 0; i < N; i++) begin
      r_write[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0; r_prot[i] = '0;
    end
    bus.m_pready = 1'b0;
    bus.m_prdata = '0;
    cap_rdata = '0; cap_err = 1'b0;
    model_reset();
    #1;
    step();
    do_reset();

    // Single write from requester 0, bridge ready in first access cycle
    serve(3'b001, 1, 0, 32'h10, 1'b1);
    check_eq("t1_latency", lat, 2);
    check_eq("t1_who", order[0], 0);

    // Tie after reset: 0 then 1
    do_reset();
    serve(3'b011, 2, 0, 32'h40, 1'b1);
    check_eq("t2_len", order.size(), 2);
    if (order.size() == 2) begin
      check_eq("t2_first", order[0], 0);
      check_eq("t2_second", order[1], 1);
    end

    // Three requesters held continuously: strict rotation
    do_reset();
    serve(3'b111, 6, 0, 32'h100, 1'b1);
    check_eq("t3_len", order.size(), 6);
    for (int k = 0; k < 6 && k < order.size(); k++) check_eq("t3_order", order[k], k % 3);

    // Wait-stated read from requester 1
    bus.m_prdata = 32'hDEADBEEF;
    serve(3'b010, 1, TO_EN ? 2 : 5, 32'h20, 1'b0);
    check_eq("t4_rdata", cap_rdata, 32'hDEADBEEF);
    check_eq("t4_err", cap_err, 0);
    check_eq("t4_latency", lat, TO_EN ? 4 : 7);

`ifdef APB_ARB_TIMEOUT_EN
    do_reset();
    serve(3'b001, 1, 1000, 32'h30, 1'b0);
    check_eq("t5_err", cap_err, 1);
    check_eq("t5_rdata", cap_rdata, 0);
    check_eq("t5_latency", lat, 1 + int'(TO));
    serve(3'b010, 1, 0, 32'h34, 1'b0);
    check_eq("t5_next_err", cap_err, 0);
`endif

    // Asynchronous reset in the access phase
    new_req(0);
    bus.m_pready = 1'b0;
    step();
    step();
    check_eq("t6_in_access", m_active && m_age == 1, 1);
    bus.m_pready = 1'b1;
    a_prst_n = 1'b0;
    #1;
    check_eq("t6_m_psel", bus.m_psel, 0);
    check_eq("t6_m_penable", bus.m_penable, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_s_pready", bus.s_pready, 0);
    model_reset();
    r_sel = '0;
    bus.m_pready = 1'b0;
    step();
    a_prst_n = 1'b1;
    serve(3'b011, 1, 0, 32'h50, 1'b1);
    check_eq("t6_tie_winner", order[0], 0);

    // Random traffic
    total_comp = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.m_prdata = $urandom;
      bus.m_pready = ($urandom_range(0, 2) == 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (comp_mask[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else r_sel[i] = 1'b0;
        end else if (r_sel[i]) begin
          if ($urandom_range(0, 31) == 0) r_sel[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
    end
    check_eq("rand_activity", total_comp > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
